// File: rtl/conv_pkg.sv
// Shared constants and types for the ASCII-to-element loader of the convolution path.
// Optional build macro: CONV_LOADER_SIGNED_EN (adds '-' and two's complement elements).
package conv_pkg;

  localparam int KERNEL_N = 9;
  localparam int IMAGE_N  = 120;
  localparam int FRAME_N  = KERNEL_N + IMAGE_N;
  localparam int DATA_W   = 8;
  localparam int ACC_W    = 12;

  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] ASCII_TAB   = 8'h09;
  localparam logic [7:0] ASCII_COMMA = 8'h2C;
  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_LF    = 8'h0A;
  localparam logic [7:0] ASCII_ZERO  = 8'h30;
  localparam logic [7:0] ASCII_NINE  = 8'h39;
  localparam logic [7:0] ASCII_MINUS = 8'h2D;

  typedef enum logic [1:0] {
    CC_DIGIT,
    CC_SEP,
    CC_MINUS,
    CC_ILLEGAL
  } char_class_t;

  typedef enum logic [1:0] {
    ST_SEP,
    ST_NUM
`ifdef CONV_LOADER_SIGNED_EN
    , ST_NEG
`endif
  } parse_state_t;

endpackage

// File: rtl/conv_char_classify.sv
// Combinational byte classifier: sorts a received byte into digit, separator,
// minus or illegal and extracts the decimal digit value.
module conv_char_classify
  import conv_pkg::*;
(
  input  logic [7:0]  data,
  output char_class_t char_class,
  output logic [3:0]  digit
);

  // Classify the byte; the digit value is only meaningful for CC_DIGIT.
  always_comb begin
    char_class = CC_ILLEGAL;
    digit      = 4'd0;
    if (data >= ASCII_ZERO && data <= ASCII_NINE) begin
      char_class = CC_DIGIT;
      digit      = data[3:0];
    end else if (data == ASCII_SPACE || data == ASCII_TAB || data == ASCII_COMMA ||
                 data == ASCII_CR || data == ASCII_LF) begin
      char_class = CC_SEP;
    end else if (data == ASCII_MINUS) begin
      char_class = CC_MINUS;
    end
  end

endmodule

// File: rtl/conv_ascii_loader.sv
// Parses the UART byte stream as separator-delimited ASCII decimal numbers and
// emits 9 kernel elements followed by 120 image elements per frame.
// Optional build macro: CONV_LOADER_SIGNED_EN (leading '-' accepted, values
// clamped to -128..127 and emitted as two's complement).
module conv_ascii_loader
  import conv_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              uart_rx_valid,
  input  logic [7:0]        uart_rx_data,
  output logic              elem_valid,
  output logic [DATA_W-1:0] elem_data,
  output logic              elem_is_kernel,
  output logic [7:0]        elem_idx,
  output logic              frame_done,
  output logic              err_illegal,
  output logic              err_overflow,
  output logic              busy
);

  parse_state_t     state_q, state_d;
  char_class_t      cls;
  logic [3:0]       digit;
  logic [ACC_W-1:0] acc_q, acc_d, acc_step, acc_limit, emit_val;
  logic             neg_q, neg_d;
  logic [7:0]       count_q, count_d;
  logic             emit, err, ovf_hit, frame_last, ovf_clear_pending;

  conv_char_classify u_classify (
    .data       (uart_rx_data),
    .char_class (cls),
    .digit      (digit)
  );

  assign frame_last = (count_q == 8'(FRAME_N - 1));
  assign busy       = (count_q != 8'd0) || (state_q != ST_SEP);
  assign emit_val   = neg_q ? (ACC_W'(0) - acc_q) : acc_q;

`ifdef CONV_LOADER_SIGNED_EN
  assign acc_limit = neg_q ? ACC_W'(1 << (DATA_W - 1)) : ACC_W'((1 << (DATA_W - 1)) - 1);
`else
  assign acc_limit = ACC_W'((1 << DATA_W) - 1);
`endif

  // Parser state register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_SEP;
    else     state_q <= state_d;
  end

  // Next-state decode; every error path and enable-low lands back in SEP.
  always_comb begin
    state_d = state_q;
    if (!enable) begin
      state_d = ST_SEP;
    end else if (uart_rx_valid) begin
      case (state_q)
        ST_SEP: begin
          if (cls == CC_DIGIT) state_d = ST_NUM;
`ifdef CONV_LOADER_SIGNED_EN
          else if (cls == CC_MINUS) state_d = ST_NEG;
`endif
          else state_d = ST_SEP;
        end
        ST_NUM:  state_d = (cls == CC_DIGIT) ? ST_NUM : ST_SEP;
`ifdef CONV_LOADER_SIGNED_EN
        ST_NEG:  state_d = (cls == CC_DIGIT) ? ST_NUM : ST_SEP;
`endif
        default: state_d = ST_SEP;
      endcase
    end
  end

  // Token datapath: accumulate with clamping, decide emit/error, advance the element counter.
  always_comb begin
    emit     = 1'b0;
    err      = 1'b0;
    ovf_hit  = 1'b0;
    acc_d    = acc_q;
    neg_d    = neg_q;
    count_d  = count_q;
    acc_step = ((state_q == ST_NUM) ? ACC_W'(acc_q * ACC_W'(10)) : ACC_W'(0)) + ACC_W'(digit);
    if (!enable) begin
      acc_d   = '0;
      neg_d   = 1'b0;
      count_d = '0;
    end else if (uart_rx_valid) begin
      case (state_q)
        ST_SEP: begin
          case (cls)
            CC_DIGIT: begin
              if (acc_step > acc_limit) begin
                acc_d   = acc_limit;
                ovf_hit = 1'b1;
              end else begin
                acc_d = acc_step;
              end
            end
            CC_SEP: ;
`ifdef CONV_LOADER_SIGNED_EN
            CC_MINUS: begin
              neg_d = 1'b1;
              acc_d = '0;
            end
`endif
            default: err = 1'b1;
          endcase
        end
        ST_NUM: begin
          case (cls)
            CC_DIGIT: begin
              if (acc_step > acc_limit) begin
                acc_d   = acc_limit;
                ovf_hit = 1'b1;
              end else begin
                acc_d = acc_step;
              end
            end
            CC_SEP:  emit = 1'b1;
            default: err  = 1'b1;
          endcase
        end
`ifdef CONV_LOADER_SIGNED_EN
        ST_NEG: begin
          if (cls == CC_DIGIT) begin
            if (acc_step > acc_limit) begin
              acc_d   = acc_limit;
              ovf_hit = 1'b1;
            end else begin
              acc_d = acc_step;
            end
          end else begin
            err = 1'b1;
          end
        end
`endif
        default: err = 1'b1;
      endcase
      if (emit) begin
        acc_d   = '0;
        neg_d   = 1'b0;
        count_d = frame_last ? 8'd0 : count_q + 8'd1;
      end
      if (err) begin
        acc_d   = '0;
        neg_d   = 1'b0;
        count_d = '0;
      end
    end
  end

  // Accumulator, sign flag and element counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q   <= '0;
      neg_q   <= 1'b0;
      count_q <= '0;
    end else begin
      acc_q   <= acc_d;
      neg_q   <= neg_d;
      count_q <= count_d;
    end
  end

  // Registered element strobes; data, section and index hold between strobes.
  always_ff @(posedge clk) begin
    if (rst) begin
      elem_valid     <= 1'b0;
      elem_data      <= '0;
      elem_is_kernel <= 1'b1;
      elem_idx       <= '0;
      frame_done     <= 1'b0;
      err_illegal    <= 1'b0;
    end else begin
      elem_valid  <= emit;
      frame_done  <= emit && frame_last;
      err_illegal <= err;
      if (emit) begin
        elem_data      <= emit_val[DATA_W-1:0];
        elem_is_kernel <= (count_q < 8'(KERNEL_N));
        elem_idx       <= (count_q < 8'(KERNEL_N)) ? count_q : count_q - 8'(KERNEL_N);
      end
    end
  end

  // Sticky overflow flag: stays up through frame_done and drops the cycle after.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_overflow      <= 1'b0;
      ovf_clear_pending <= 1'b0;
    end else if (!enable || (uart_rx_valid && err)) begin
      err_overflow      <= 1'b0;
      ovf_clear_pending <= 1'b0;
    end else begin
      if (ovf_clear_pending) err_overflow <= ovf_hit;
      else if (ovf_hit)      err_overflow <= 1'b1;
      ovf_clear_pending <= emit && frame_last;
    end
  end

endmodule

// File: doc/conv_ascii_loader.md
# conv_ascii_loader

Upstream input stage of the convolution path: sits between the UART receiver and the convolution engine. It parses the raw UART byte stream as whitespace/comma-separated ASCII decimal numbers and emits one parsed element per token, 9 kernel elements followed by 120 image elements (10x12), row-major. It also flags framing and range errors, so the engine consumes clean numeric elements instead of raw bytes.

## Interface
- KERNEL_N, 9, kernel elements per frame
- IMAGE_N, 120, image elements per frame
- DATA_W, 8, element width

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- enable  in  1  parser active; low clears all state
- uart_rx_valid  in  1  one-cycle strobe, byte available
- uart_rx_data  in  8  received byte
- elem_valid  out  1  one-cycle strobe, element on elem_data
- elem_data  out  DATA_W  parsed value (unsigned; two's complement with CONV_LOADER_SIGNED_EN)
- elem_is_kernel  out  1  element belongs to kernel section
- elem_idx  out  8  index within current section (kernel 0..8, image 0..119)
- frame_done  out  1  one-cycle strobe, coincident with last image element
- err_illegal  out  1  one-cycle strobe, illegal character seen
- err_overflow  out  1  sticky, a token was clamped this frame
- busy  out  1  frame in progress (count≠0 or token partially parsed)

## Operation
- Character classes: digit '0'-'9'; separator = space, tab, ',', CR, LF; all others illegal ('-' legal only with macro).
- States: SEP (between tokens), NUM (accumulating), NEG (sign seen, macro only).
- SEP: digit → NUM, acc=digit; separator → stay; illegal → error.
- NUM: digit → acc=acc*10+d; separator → emit acc, → SEP; illegal → error.
- Accumulator 12 bits; after each digit, if acc>255 clamp to 255 and set err_overflow. Further digits keep clamped value.
- Element counter 0..KERNEL_N+IMAGE_N-1; elem_is_kernel = count<KERNEL_N; elem_idx = count or count-KERNEL_N.
- Emitting element count KERNEL_N+IMAGE_N-1 asserts frame_done, counter wraps to 0, err_overflow clears on the following cycle.
- Last token requires a trailing separator; no timeout flush.
- Error: err_illegal pulses, partial token discarded, counter resets to 0 (frame restarts), state → SEP, err_overflow cleared.
- Bytes with enable=0 ignored; enable low forces SEP, count 0, acc 0, err_overflow 0.

## Timing
- Reset values: elem_valid 0, elem_data 0, elem_is_kernel 1, elem_idx 0, frame_done 0, err_illegal 0, err_overflow 0, busy 0; state SEP.
- Latency: elem_valid/frame_done/err_illegal assert on the cycle after the uart_rx_valid carrying the separator/illegal byte; all registered.
- elem_data, elem_is_kernel, elem_idx valid only while elem_valid=1; held otherwise.
- No backpressure: downstream must accept one element per strobe. Minimum strobe spacing equals byte spacing.
- uart_rx_valid on consecutive cycles must be handled (one byte per cycle).
- enable falling in the same cycle as uart_rx_valid: byte dropped, clear wins.
- rst mid-frame: next cycle all outputs at reset values, partial frame lost.

## Configuration
- CONV_LOADER_SIGNED_EN defined: '-' legal in SEP → NEG; NEG requires digit next (→ NUM with negative flag), separator/illegal/second '-' → error. Clamp range -128..127; elem_data two's complement.
- Undefined: '-' illegal; values unsigned 0..255; NEG state not built.

## Structure
- Package conv_pkg: KERNEL_N, IMAGE_N, FRAME_N, ASCII constants (space, tab, comma, CR, LF, '0', '-'), character class enum, parser state enum.
- One sub-module: conv_char_classify (combinational byte → class + digit value).

## Test plan
- "1 2 3 4 5 6 7 8 9 " then 120 × "0," → 9 kernel strobes values 1..9 idx 0..8, 120 image strobes, frame_done with image idx 119.
- "  12,,\r\n034 " → exactly two elements: 12, 34; no error.
- "300 " → elem_data 255, err_overflow 1 until frame end.
- 5 kernel values then "a" → err_illegal pulse, next "7 " emits kernel idx 0 value 7.
- enable dropped after 50 elements, re-raised, full frame → first element kernel idx 0, frame_done after 129 elements.
- With CONV_LOADER_SIGNED_EN: "-5 -200 127 - " → 0xFB, 0x80 (overflow set), 0x7F, then err_illegal on "- ".
